// File: rtl/mul_share_pkg.sv
// Shared types and defaults for the two-requester shared multiplier.
//   state_t : controller state encoding
//   id_t    : requester identifier (0 or 1)
//   W_DEF / LAT_DEF : default operand width and multicycle settling budget
//   CNT_W   : width of the settling counter (covers LAT-1 for LAT up to 8)
package mul_share_pkg;

    localparam int unsigned W_DEF   = 4;
    localparam int unsigned LAT_DEF = 2;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic id_t;

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Handshake bundle between two operand sources, the arbiter and the product consumer.
//   req0_* / req1_* : valid/ready operand channels (a, b are W bits)
//   rsp_*           : valid/ready product channel (product is 2W bits, id selects owner)
//   slave  : arbiter view;  master : requester/consumer view
interface mul_share_arbiter_if
    import mul_share_pkg::*;
#(
    parameter int unsigned W = W_DEF
);

    logic           req0_valid;
    logic           req0_ready;
    logic [W-1:0]   req0_a;
    logic [W-1:0]   req0_b;
    logic           req1_valid;
    logic           req1_ready;
    logic [W-1:0]   req1_a;
    logic [W-1:0]   req1_b;
    logic           rsp_valid;
    logic           rsp_ready;
    id_t            rsp_id;
    logic [2*W-1:0] rsp_product;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_product
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_product
    );

endinterface

// File: rtl/mul_share_rr2.sv
// Two-way round-robin grant (combinational).
//   valid0/valid1 : requests
//   last_grant    : requester granted most recently; loses a tie
//   enable        : grants only issued while enabled
//   grant0/grant1 : one-hot or zero grant
module mul_share_rr2
    import mul_share_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  id_t  last_grant,
    input  logic enable,
    output logic grant0,
    output logic grant1
);

    // A lone request always wins; on a tie the requester that did not win last time goes.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (enable) begin
            grant0 = valid0 && (!valid1 || (last_grant == 1'b1));
            grant1 = valid1 && (!valid0 || (last_grant == 1'b0));
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one unsigned W x W multiplier between two valid/ready requesters.
// Round-robin grant in IDLE, operands captured on accept, product registered
// LAT cycles later and held with its requester id until the consumer takes it.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : operand and response handshakes (slave view)
//   busy       : high whenever the controller is not IDLE
// Optional (MUL_SHARE_ARBITER_STATS_EN): grant_cnt0/grant_cnt1, saturating
// 8-bit accept counters per requester.
// LAT must lie in 1..8.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int unsigned W   = W_DEF,
    parameter int unsigned LAT = LAT_DEF
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    mul_share_arbiter_if.slave      bus,
    output logic                    busy
`ifdef MUL_SHARE_ARBITER_STATS_EN
    ,
    output logic [7:0]              grant_cnt0,
    output logic [7:0]              grant_cnt1
`endif
);

    localparam int unsigned PW = 2 * W;

    state_t           state;
    id_t              last_grant;
    id_t              id_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [CNT_W-1:0] cnt;
    logic             grant0;
    logic             grant1;
    logic             acc0;
    logic             acc1;

    mul_share_rr2 u_rr (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last_grant (last_grant),
        .enable     (state == IDLE),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign acc0           = bus.req0_valid && grant0;
    assign acc1           = bus.req1_valid && grant1;

    // Controller: capture on accept, count down the settling budget, hold response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            busy            <= 1'b0;
            last_grant      <= 1'b1;
            id_q            <= 1'b0;
            a_q             <= '0;
            b_q             <= '0;
            cnt             <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_id      <= 1'b0;
            bus.rsp_product <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (acc0 || acc1) begin
                        a_q        <= acc1 ? bus.req1_a : bus.req0_a;
                        b_q        <= acc1 ? bus.req1_b : bus.req0_b;
                        id_q       <= acc1;
                        last_grant <= acc1;
                        cnt        <= CNT_W'(LAT - 1);
                        state      <= BUSY;
                        busy       <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        bus.rsp_product <= PW'(a_q) * PW'(b_q);
                        bus.rsp_id      <= id_q;
                        bus.rsp_valid   <= 1'b1;
                        state           <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                        busy          <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MUL_SHARE_ARBITER_STATS_EN
    // Per-requester accept counters, saturating at 255.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt0 <= 8'd0;
            grant_cnt1 <= 8'd0;
        end else begin
            if (acc0 && (grant_cnt0 != 8'hFF)) grant_cnt0 <= grant_cnt0 + 8'd1;
            if (acc1 && (grant_cnt1 != 8'hFF)) grant_cnt1 <= grant_cnt1 + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: directed vector table, hand-written
// corner sequences, randomized traffic against a transaction-level model, and
// latency checks on LAT=1 and LAT=8 instances.
module tb_mul_share_arbiter;
    import mul_share_pkg::*;

    localparam int unsigned W   = 4;
    localparam int unsigned LAT = 2;
    localparam int unsigned PW  = 2 * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic busy, busy1, busy8;

    mul_share_arbiter_if #(.W(W)) bus  ();
    mul_share_arbiter_if #(.W(W)) bus1 ();
    mul_share_arbiter_if #(.W(W)) bus8 ();

`ifdef MUL_SHARE_ARBITER_STATS_EN
    logic [7:0] gc0, gc1, gc0_1, gc1_1, gc0_8, gc1_8;
`endif

    mul_share_arbiter #(.W(W), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy(busy)
`ifdef MUL_SHARE_ARBITER_STATS_EN
        , .grant_cnt0(gc0), .grant_cnt1(gc1)
`endif
    );

    mul_share_arbiter #(.W(W), .LAT(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .busy(busy1)
`ifdef MUL_SHARE_ARBITER_STATS_EN
        , .grant_cnt0(gc0_1), .grant_cnt1(gc1_1)
`endif
    );

    mul_share_arbiter #(.W(W), .LAT(8)) dut_l8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8.slave), .busy(busy8)
`ifdef MUL_SHARE_ARBITER_STATS_EN
        , .grant_cnt0(gc0_8), .grant_cnt1(gc1_8)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          m_busy, m_resp, m_last, m_id, m_pend_id;
    int          m_age;
    bit [PW-1:0] m_prod, m_pend_prod;
    int          m_stat0, m_stat1;

    // Which requester the rules grant: lone request wins, tie goes to the one not served last.
    function automatic int pick(input bit v0, input bit v1, input bit last);
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
        if (v0 && v1)  return last ? 0 : 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_resp = 0; m_last = 1; m_id = 0; m_pend_id = 0;
        m_age = 0; m_prod = '0; m_pend_prod = '0; m_stat0 = 0; m_stat1 = 0;
    endtask

    task automatic model_edge(input bit rst, input bit v0, input int a0, input int b0,
                              input bit v1, input int a1, input int b1, input bit rr);
        int g;
        if (rst) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            g = pick(v0, v1, m_last);
            if (g >= 0) begin
                m_busy      = 1;
                m_age       = 0;
                m_pend_id   = (g == 1);
                m_pend_prod = (g == 1) ? PW'(a1 * b1) : PW'(a0 * b0);
                m_last      = (g == 1);
                if (g == 0) m_stat0 = (m_stat0 < 255) ? m_stat0 + 1 : 255;
                else        m_stat1 = (m_stat1 < 255) ? m_stat1 + 1 : 255;
            end
        end else if (!m_resp) begin
            m_age++;
            if (m_age == LAT) begin
                m_resp = 1;
                m_prod = m_pend_prod;
                m_id   = m_pend_id;
            end
        end else if (rr) begin
            m_busy = 0;
            m_resp = 0;
        end
    endtask

    task automatic drive(input bit v0, input int a0, input int b0,
                         input bit v1, input int a1, input int b1, input bit rr, input bit rst);
        bus.req0_valid = v0; bus.req0_a = W'(a0); bus.req0_b = W'(b0);
        bus.req1_valid = v1; bus.req1_a = W'(a1); bus.req1_b = W'(b1);
        bus.rsp_ready  = rr;
        rst_n          = !rst;
    endtask

    // One clock against the model: readys checked before the edge, registered outputs after.
    task automatic cycle(input bit v0, input int a0, input int b0,
                         input bit v1, input int a1, input int b1, input bit rr, input bit rst);
        int g;
        drive(v0, a0, b0, v1, a1, b1, rr, rst);
        #1;
        g = m_busy ? -1 : pick(v0, v1, m_last);
        chk("req0_ready", 32'(bus.req0_ready), 32'(g == 0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(g == 1));
        @(posedge clk);
        model_edge(rst, v0, a0, b0, v1, a1, b1, rr);
        #1;
        chk("rsp_valid",   32'(bus.rsp_valid),   32'(m_resp));
        chk("rsp_id",      32'(bus.rsp_id),      32'(m_id));
        chk("rsp_product", 32'(bus.rsp_product), 32'(m_prod));
        chk("busy",        32'(busy),            32'(m_busy));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         v0; int a0; int b0;
        bit         v1; int a1; int b1;
        bit         rr;
        bit         er0; bit er1;
        bit         ev;  bit eid; int ep; bit eb;
    } vec_t;

    vec_t tv[13];

    task automatic apply_vec(input int i, input vec_t v);
        drive(v.v0, v.a0, v.b0, v.v1, v.a1, v.b1, v.rr, 1'b0);
        #1;
        chk($sformatf("vec%0d req0_ready", i), 32'(bus.req0_ready), 32'(v.er0));
        chk($sformatf("vec%0d req1_ready", i), 32'(bus.req1_ready), 32'(v.er1));
        @(posedge clk);
        model_edge(1'b0, v.v0, v.a0, v.b0, v.v1, v.a1, v.b1, v.rr);
        #1;
        chk($sformatf("vec%0d rsp_valid", i),   32'(bus.rsp_valid),   32'(v.ev));
        chk($sformatf("vec%0d rsp_id", i),      32'(bus.rsp_id),      32'(v.eid));
        chk($sformatf("vec%0d rsp_product", i), 32'(bus.rsp_product), 32'(v.ep));
        chk($sformatf("vec%0d busy", i),        32'(busy),            32'(v.eb));
    endtask

    initial begin
        logic [PW-1:0] held_prod;
        bit            held_id;
        int            n;

        // single 3*5 from req0, then sustained contention 7*9 vs 15*15
        tv[0]  = '{1, 3, 5,  0, 0, 0,   1, 1, 0, 0, 0, 0,   1};
        tv[1]  = '{0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 0,   1};
        tv[2]  = '{0, 0, 0,  0, 0, 0,   1, 0, 0, 1, 0, 15,  1};
        tv[3]  = '{0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 15,  0};
        tv[4]  = '{1, 7, 9,  1, 15, 15, 1, 0, 1, 0, 0, 15,  1};
        tv[5]  = '{1, 7, 9,  1, 15, 15, 1, 0, 0, 0, 0, 15,  1};
        tv[6]  = '{1, 7, 9,  1, 15, 15, 1, 0, 0, 1, 1, 225, 1};
        tv[7]  = '{1, 7, 9,  1, 15, 15, 1, 0, 0, 0, 1, 225, 0};
        tv[8]  = '{1, 7, 9,  1, 15, 15, 1, 1, 0, 0, 1, 225, 1};
        tv[9]  = '{1, 7, 9,  1, 15, 15, 1, 0, 0, 0, 1, 225, 1};
        tv[10] = '{1, 7, 9,  1, 15, 15, 1, 0, 0, 1, 0, 63,  1};
        tv[11] = '{1, 7, 9,  1, 15, 15, 1, 0, 0, 0, 0, 63,  0};
        tv[12] = '{1, 7, 9,  1, 15, 15, 1, 0, 1, 0, 0, 63,  1};

        foreach (bus1.req0_a[i]) begin end
        bus1.req0_valid = 0; bus1.req0_a = '0; bus1.req0_b = '0;
        bus1.req1_valid = 0; bus1.req1_a = '0; bus1.req1_b = '0; bus1.rsp_ready = 0;
        bus8.req0_valid = 0; bus8.req0_a = '0; bus8.req0_b = '0;
        bus8.req1_valid = 0; bus8.req1_a = '0; bus8.req1_b = '0; bus8.rsp_ready = 0;

        // reset, then idle outputs
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reset rsp_valid",   32'(bus.rsp_valid),   32'd0);
        chk("reset rsp_id",      32'(bus.rsp_id),      32'd0);
        chk("reset rsp_product", 32'(bus.rsp_product), 32'd0);
        chk("reset busy",        32'(busy),            32'd0);
        chk("idle req0_ready",   32'(bus.req0_ready),  32'd0);
        chk("idle req1_ready",   32'(bus.req1_ready),  32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) apply_vec(i, tv[i]);
        repeat (LAT + 2) cycle(0, 0, 0, 0, 0, 0, 1, 0);

        // backpressure: response held 10+ cycles with both requesters pushing
        cycle(1, 4, 6, 1, 2, 3, 0, 0);
        repeat (LAT) cycle(1, 4, 6, 1, 2, 3, 0, 0);
        held_prod = bus.rsp_product;
        held_id   = bus.rsp_id;
        for (int i = 0; i < 10; i++) begin
            cycle(1, 4, 6, 1, 2, 3, 0, 0);
            chk("hold product", 32'(bus.rsp_product), 32'(held_prod));
            chk("hold id",      32'(bus.rsp_id),      32'(held_id));
        end
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);

        // reset mid-BUSY abandons the op; next tie goes to req0
        cycle(0, 0, 0, 1, 9, 9, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        drive(1, 2, 2, 1, 3, 3, 1, 0);
        #1;
        chk("post-reset tie req0_ready", 32'(bus.req0_ready), 32'd1);
        chk("post-reset tie req1_ready", 32'(bus.req1_ready), 32'd0);
        @(posedge clk);
        model_edge(0, 1, 2, 2, 1, 3, 3, 1);
        #1;
        repeat (LAT + 2) cycle(0, 0, 0, 0, 0, 0, 1, 0);

        // extreme operands
        cycle(1, 15, 15, 0, 0, 0, 1, 0);
        repeat (LAT + 1) cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0, 13, 1, 0);
        repeat (LAT + 1) cycle(0, 0, 0, 0, 0, 0, 1, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 99) == 0);
        end
        repeat (LAT + 3) cycle(0, 0, 0, 0, 0, 0, 1, 0);

`ifdef MUL_SHARE_ARBITER_STATS_EN
        for (int i = 0; i < 300 * (LAT + 2); i++) cycle(1, 5, 5, 0, 0, 0, 1, 0);
        chk("grant_cnt0 saturated", 32'(gc0), 32'd255);
        chk("grant_cnt1",           32'(gc1), 32'(m_stat1));
`endif

        // LAT=1 instance: rsp_valid one cycle after accept
        bus1.req0_valid = 1; bus1.req0_a = 4'd11; bus1.req0_b = 4'd12; bus1.rsp_ready = 0;
        #1;
        chk("lat1 req0_ready", 32'(bus1.req0_ready), 32'd1);
        @(posedge clk);
        #1;
        bus1.req0_valid = 0;
        n = 0;
        while (!bus1.rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("lat1 latency", 32'(n), 32'd1);
        chk("lat1 product", 32'(bus1.rsp_product), 32'd132);
        bus1.rsp_ready = 1;
        @(posedge clk);
        #1;
        chk("lat1 drained", 32'(busy1), 32'd0);

        // LAT=8 instance
        bus8.req1_valid = 1; bus8.req1_a = 4'd15; bus8.req1_b = 4'd14; bus8.rsp_ready = 0;
        #1;
        chk("lat8 req1_ready", 32'(bus8.req1_ready), 32'd1);
        @(posedge clk);
        #1;
        bus8.req1_valid = 0;
        n = 0;
        while (!bus8.rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("lat8 latency", 32'(n), 32'd8);
        chk("lat8 product", 32'(bus8.rsp_product), 32'd210);
        chk("lat8 id",      32'(bus8.rsp_id),      32'd1);
        bus8.rsp_ready = 1;
        @(posedge clk);
        #1;
        chk("lat8 drained", 32'(busy8), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
